// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
// Sequences the KxK convolution window stream between the column line buffer
// and the PE array. One Kx1 column is accepted per handshake. The first K-1
// columns of each row fill the window registers (FILL). Every later column
// completes a window (RUN). After the last column of the frame the final
// window is drained (DRAIN).
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. Valid never waits for ready. Once win_valid is raised, the window
// coordinates stay stable until win_ready is seen. col_ready_out is
// combinational and may depend on win_ready, so a window can be consumed and
// replaced in the same cycle.
//
// Optional build macro SCHED_STALL_CNT_EN adds a 16-bit saturating stall_cnt
// output. It counts busy cycles without a column shift, excluding DRAIN.
module conv_window_scheduler #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  input  logic        col_valid_in,
  output logic        col_ready_out,
  output logic        shift_en,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [4:0]  out_x,
  output logic [4:0]  out_y,
  output logic        row_last,
`ifdef SCHED_STALL_CNT_EN
  output logic        frame_done,
  output logic [15:0] stall_cnt
`else
  output logic        frame_done
`endif
);

  localparam int OUT_H = IMG_H - K + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] col_x_q, col_x_d;
  logic [4:0] row_y_q, row_y_d;

  logic       win_valid_q;
  logic [4:0] out_x_q, out_y_q;
  logic       row_last_q;
  logic       frame_done_q;

  logic       win_load;
  logic       win_take;

  // FSM state and column/row counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_x_q <= '0;
      row_y_q <= '0;
    end else begin
      state_q <= state_d;
      col_x_q <= col_x_d;
      row_y_q <= row_y_d;
    end
  end

  // Next-state logic, counter updates and column-side ready
  always_comb begin
    state_d       = state_q;
    col_x_d       = col_x_q;
    row_y_d       = row_y_q;
    col_ready_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          col_x_d = '0;
          row_y_d = '0;
        end
      end
      S_FILL: begin
        col_ready_out = 1'b1;
        if (col_valid_in) begin
          col_x_d = col_x_q + 5'd1;
          if (col_x_q == 5'(K - 2)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A pending window blocks intake unless it is consumed this cycle.
        col_ready_out = !win_valid_q || win_ready;
        if (col_valid_in && col_ready_out) begin
          if (col_x_q == 5'(IMG_W - 1)) begin
            if (row_y_q == 5'(OUT_H - 1)) begin
              state_d = S_DRAIN;
            end else begin
              col_x_d = '0;
              row_y_d = row_y_q + 5'd1;
              state_d = S_FILL;
            end
          end else begin
            col_x_d = col_x_q + 5'd1;
          end
        end
      end
      S_DRAIN: begin
        if (win_valid_q && win_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign shift_en = col_valid_in && col_ready_out;
  assign busy     = (state_q != S_IDLE);
  assign win_load = (state_q == S_RUN) && shift_en;
  assign win_take = win_valid_q && win_ready;

  // Window-valid register with coordinates; a new load wins over a consume
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      row_last_q  <= 1'b0;
    end else if (win_load) begin
      win_valid_q <= 1'b1;
      out_x_q     <= col_x_q - 5'(K - 1);
      out_y_q     <= row_y_q;
      row_last_q  <= (col_x_q == 5'(IMG_W - 1));
    end else if (win_take) begin
      win_valid_q <= 1'b0;
    end
  end

  // One-cycle pulse after the final window of a frame is taken
  always_ff @(posedge clk) begin
    if (rst) frame_done_q <= 1'b0;
    else     frame_done_q <= (state_q == S_DRAIN) && win_take;
  end

  assign win_valid  = win_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign row_last   = row_last_q;
  assign frame_done = frame_done_q;

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating stall counter. It holds while IDLE, so the value stays frozen after frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      stall_q <= '0;
    end else if (busy && !shift_en && (state_q != S_DRAIN) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Testbench for conv_window_scheduler: randomized column/window handshakes
// scored against a frame-level model (accepted column index -> window coords).
module tb_conv_window_scheduler;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int TOTAL = IMG_W * OUT_H;   // columns accepted per frame
  localparam int NWIN  = OUT_W * OUT_H;   // windows per frame

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       col_valid_in = 1'b0;
  logic       win_ready = 1'b0;
  logic       busy, col_ready_out, shift_en, win_valid, row_last, frame_done;
  logic [4:0] out_x, out_y;
`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  conv_window_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .col_valid_in(col_valid_in),
    .col_ready_out(col_ready_out),
    .shift_en(shift_en),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .out_x(out_x),
    .out_y(out_y),
    .row_last(row_last),
`ifdef SCHED_STALL_CNT_EN
    .frame_done(frame_done),
    .stall_cnt(stall_cnt)
`else
    .frame_done(frame_done)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  bit         m_active;
  int         m_n;         // columns accepted this frame
  bit         m_done;      // frame_done expected this cycle
  int         m_stall;
  logic [9:0] exp_q[$];    // {x, y} of windows produced but not yet taken

  // observed values of the last cycle
  logic       obs_ready, obs_shift, obs_wv, obs_busy, obs_fd, obs_rl, obs_hs;
  logic [4:0] obs_x, obs_y;
  logic [15:0] obs_stall;

  function automatic logic rnd(input int pct);
    return (int'($urandom_range(99, 0)) < pct);
  endfunction

  task automatic do_reset(input int cycles);
    rst = 1'b1; start = 1'b0; col_valid_in = 1'b0; win_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    m_active = 0; m_n = 0; m_done = 0; m_stall = 0;
    exp_q.delete();
  endtask

  // Driver + scoreboard for one clock cycle
  task automatic cycle(input logic cv, input logic wr, input logic st);
    logic       exp_ready;
    logic [9:0] w;
    bit         popped, was_active;
    int         c;
    col_valid_in = cv; win_ready = wr; start = st;
    #4;
    obs_ready = col_ready_out; obs_shift = shift_en; obs_wv = win_valid;
    obs_busy = busy; obs_fd = frame_done; obs_rl = row_last;
    obs_x = out_x; obs_y = out_y; obs_hs = win_valid && wr;
`ifdef SCHED_STALL_CNT_EN
    obs_stall = stall_cnt;
`else
    obs_stall = '0;
`endif
    exp_ready = m_active && (m_n < TOTAL) &&
                (((m_n % IMG_W) < K - 1) || (exp_q.size() == 0) || wr);

    n_checks++;
    if (obs_busy !== m_active) begin
      n_fail++; $display("FAIL busy: got %b exp %b (n=%0d)", obs_busy, m_active, m_n);
    end
    n_checks++;
    if (obs_ready !== exp_ready) begin
      n_fail++; $display("FAIL col_ready_out: got %b exp %b (n=%0d)", obs_ready, exp_ready, m_n);
    end
    n_checks++;
    if (obs_shift !== (cv && exp_ready)) begin
      n_fail++; $display("FAIL shift_en: got %b exp %b (n=%0d)", obs_shift, cv && exp_ready, m_n);
    end
    n_checks++;
    if (obs_fd !== m_done) begin
      n_fail++; $display("FAIL frame_done: got %b exp %b", obs_fd, m_done);
    end
    n_checks++;
    if (obs_wv !== (exp_q.size() != 0)) begin
      n_fail++; $display("FAIL win_valid: got %b exp %b (n=%0d)", obs_wv, exp_q.size() != 0, m_n);
    end
    if (exp_q.size() != 0) begin
      w = exp_q[0];
      n_checks++;
      if (obs_x !== w[9:5] || obs_y !== w[4:0] || obs_rl !== (w[9:5] == 5'(OUT_W - 1))) begin
        n_fail++;
        $display("FAIL window coords: got (%0d,%0d,rl=%b) exp (%0d,%0d,rl=%b)",
                 obs_x, obs_y, obs_rl, w[9:5], w[4:0], w[9:5] == 5'(OUT_W - 1));
      end
    end
`ifdef SCHED_STALL_CNT_EN
    n_checks++;
    if (obs_stall !== 16'(m_stall)) begin
      n_fail++; $display("FAIL stall_cnt: got %0d exp %0d", obs_stall, m_stall);
    end
`endif

    // model update for the coming edge
    was_active = m_active;
    m_done = 0; popped = 0;
    if (exp_q.size() != 0 && wr) begin
      void'(exp_q.pop_front());
      popped = 1;
    end
    if (m_active && !(cv && exp_ready) && (m_n < TOTAL) && (m_stall < 65535)) m_stall++;
    if (cv && exp_ready) begin
      c = m_n % IMG_W;
      if (c >= K - 1) exp_q.push_back({5'(c - (K - 1)), 5'(m_n / IMG_W)});
      m_n++;
    end
    if (m_active && popped && (m_n == TOTAL) && (exp_q.size() == 0)) begin
      m_done = 1; m_active = 0;
    end
    if (st && !was_active) begin
      m_active = 1; m_n = 0; m_stall = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Randomly drives the current frame until frame_done is seen
  task automatic run_to_done(input int cv_pct, input int wr_pct,
                             output int shifts, output int hs, output bit to);
    int cyc;
    cyc = 0; shifts = 0; hs = 0; to = 0;
    while (1) begin
      cycle(rnd(cv_pct), rnd(wr_pct), 1'b0);
      if (obs_shift) shifts++;
      if (obs_hs) hs++;
      if (obs_fd) break;
      cyc++;
      if (cyc > 20000) begin to = 1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(2);
    col_valid_in = 1'b1;
    #1;
    n_checks++;
    if (win_valid !== 1'b0 || busy !== 1'b0 || col_ready_out !== 1'b0 ||
        frame_done !== 1'b0 || shift_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ctrl: wv=%b busy=%b rdy=%b fd=%b sh=%b exp all 0",
               win_valid, busy, col_ready_out, frame_done, shift_en);
    end
    n_checks++;
    if (out_x !== 5'd0 || out_y !== 5'd0 || row_last !== 1'b0) begin
      n_fail++; $display("FAIL reset coords: x=%0d y=%0d rl=%b exp 0", out_x, out_y, row_last);
    end
    col_valid_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    int shifts, hs, fd, cyc, first_win, fifth, lx, ly;
    shifts = 0; hs = 0; fd = 0; cyc = 0; first_win = -1; fifth = -1; lx = -1; ly = -1;
    cycle(1'b0, 1'b1, 1'b1);
    while (fd == 0 && cyc < 2000) begin
      cycle(1'b1, 1'b1, 1'b0);
      cyc++;
      if (obs_shift) begin shifts++; if (shifts == 5) fifth = cyc; end
      if (obs_wv && first_win < 0) begin
        first_win = cyc;
        n_checks++;
        if (obs_x !== 5'd0 || obs_y !== 5'd0) begin
          n_fail++; $display("FAIL first window: got (%0d,%0d) exp (0,0)", obs_x, obs_y);
        end
      end
      if (obs_hs) begin hs++; lx = obs_x; ly = obs_y; end
      if (obs_fd) fd++;
    end
    repeat (5) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (obs_fd) fd++;
    end
    n_checks++;
    if (shifts != TOTAL) begin n_fail++; $display("FAIL frame shifts: got %0d exp %0d", shifts, TOTAL); end
    n_checks++;
    if (hs != NWIN) begin n_fail++; $display("FAIL frame windows: got %0d exp %0d", hs, NWIN); end
    n_checks++;
    if (first_win != fifth + 1) begin
      n_fail++; $display("FAIL first window latency: got cycle %0d exp %0d", first_win, fifth + 1);
    end
    n_checks++;
    if (fd != 1) begin n_fail++; $display("FAIL frame_done count: got %0d exp 1", fd); end
    n_checks++;
    if (lx != OUT_W - 1 || ly != OUT_H - 1) begin
      n_fail++; $display("FAIL last window: got (%0d,%0d) exp (%0d,%0d)", lx, ly, OUT_W - 1, OUT_H - 1);
    end
  endtask

  task automatic test_backpressure();
    int held, shifts, hs, s2, h2;
    bit hold, done3, to, got_next;
    held = 0; done3 = 0; shifts = 0; got_next = 0;
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 200 && !done3; i++) begin
      hold = (win_valid === 1'b1) && (out_x == 5'd3) && (out_y == 5'd0) && (held < 4);
      cycle(1'b1, !hold, 1'b0);
      if (obs_shift) shifts++;
      if (hold) begin
        held++;
        n_checks++;
        if (obs_ready !== 1'b0 || obs_x !== 5'd3) begin
          n_fail++; $display("FAIL backpressure hold: rdy=%b x=%0d exp rdy=0 x=3", obs_ready, obs_x);
        end
      end else if (obs_hs && obs_x == 5'd3 && obs_y == 5'd0) begin
        done3 = 1;
      end
    end
    n_checks++;
    if (held != 4 || !done3) begin n_fail++; $display("FAIL backpressure stall: held %0d exp 4", held); end
    for (int i = 0; i < 10 && !got_next; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (obs_shift) shifts++;
      if (obs_hs) begin
        got_next = 1;
        n_checks++;
        if (obs_x !== 5'd4 || obs_y !== 5'd0) begin
          n_fail++; $display("FAIL window after stall: got (%0d,%0d) exp (4,0)", obs_x, obs_y);
        end
      end
    end
    run_to_done(100, 100, s2, h2, to);
    n_checks++;
    if (to || shifts + s2 != TOTAL) begin
      n_fail++; $display("FAIL backpressure columns: got %0d exp %0d (timeout=%b)", shifts + s2, TOTAL, to);
    end
  endtask

  task automatic test_row_wrap();
    int gap, s, h;
    bit found, to;
    found = 0; gap = 0;
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (obs_hs && obs_rl) found = 1;
    end
    n_checks++;
    if (!found || obs_x !== 5'(OUT_W - 1) || obs_y !== 5'd0) begin
      n_fail++; $display("FAIL row_last window: found=%b got (%0d,%0d) exp (23,0)", found, obs_x, obs_y);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (obs_wv) break;
      gap++;
    end
    n_checks++;
    if (gap != K - 1 || obs_x !== 5'd0 || obs_y !== 5'd1) begin
      n_fail++; $display("FAIL row wrap gap: gap %0d at (%0d,%0d) exp gap 4 at (0,1)", gap, obs_x, obs_y);
    end
    run_to_done(100, 100, s, h, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL row wrap frame: timeout"); end
  endtask

  task automatic test_start_busy_reset();
    int s, h, fd;
    bit found, to;
    found = 0; fd = 0;
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5000 && !found; i++) begin
      cycle(rnd(85), rnd(75), rnd(10));
      if (obs_hs && obs_y == 5'd10) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL reach row 10: timeout"); end
    do_reset(1);
    n_checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0 || out_x !== 5'd0 || out_y !== 5'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid-frame reset: busy=%b wv=%b x=%0d y=%0d fd=%b exp 0",
               busy, win_valid, out_x, out_y, frame_done);
    end
    repeat (6) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (obs_fd) fd++;
    end
    n_checks++;
    if (fd != 0) begin n_fail++; $display("FAIL partial frame_done: got %0d exp 0", fd); end
    cycle(1'b0, 1'b0, 1'b1);
    run_to_done(80, 60, s, h, to);
    n_checks++;
    if (to || h != NWIN || s != TOTAL) begin
      n_fail++; $display("FAIL frame after reset: windows %0d cols %0d exp %0d/%0d", h, s, NWIN, TOTAL);
    end
  endtask

  task automatic test_random_frames();
    int s, h;
    bit to;
    for (int f = 0; f < 2; f++) begin
      cycle(1'b0, 1'b0, 1'b1);
      run_to_done(int'($urandom_range(90, 40)), int'($urandom_range(90, 40)), s, h, to);
      n_checks++;
      if (to || h != NWIN || s != TOTAL) begin
        n_fail++; $display("FAIL random frame %0d: windows %0d cols %0d timeout=%b", f, h, s, to);
      end
      repeat (int'($urandom_range(4, 0))) cycle(rnd(50), rnd(50), 1'b0);
    end
  endtask

`ifdef SCHED_STALL_CNT_EN
  task automatic test_stall_cnt();
    int shifts, dropped, cyc;
    bit fd_seen;
    shifts = 0; dropped = 0; cyc = 0; fd_seen = 0;
    cycle(1'b0, 1'b1, 1'b1);
    while (!fd_seen && cyc < 2000) begin
      if (shifts == 10 && dropped < 7) begin
        cycle(1'b0, 1'b1, 1'b0);
        dropped++;
      end else begin
        cycle(1'b1, 1'b1, 1'b0);
      end
      if (obs_shift) shifts++;
      if (obs_fd) fd_seen = 1;
      cyc++;
    end
    n_checks++;
    if (!fd_seen || obs_stall !== 16'd7) begin
      n_fail++; $display("FAIL stall_cnt at frame_done: got %0d exp 7 (done=%b)", obs_stall, fd_seen);
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_stall !== 16'd7) begin n_fail++; $display("FAIL stall_cnt frozen: got %0d exp 7", obs_stall); end
  endtask
`endif

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_row_wrap();
    test_start_busy_reset();
    test_random_frames();
`ifdef SCHED_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
